// File: rtl/ama_riscv_mem_arb.sv
// ama_riscv_mem_arb
// Shares the single-port unified memory between the instruction-fetch port
// and the data port. One grant per cycle; read responses are routed back
// through an RD_LAT-deep tag pipeline so each returns to its issuing port.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration instead of
// data-port priority with a fetch starvation guard.

module ama_riscv_mem_arb #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    input  logic          dm_req_valid,
    output logic          dm_req_ready,
    input  logic [AW-1:0] dm_req_addr,
    input  logic          dm_req_we,
    input  logic [3:0]    dm_req_wmask,
    input  logic [DW-1:0] dm_req_wdata,
    output logic          dm_rsp_valid,
    output logic [DW-1:0] dm_rsp_data,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DM = 1'b1;

    logic              grant_if;
    logic              grant_dm;
    logic              grant_rd;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_src;
    logic              rsp_v;

`ifdef MEM_ARB_RR_EN
    logic prio;

    // Contention winner flips to the other port after every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= SRC_DM;
        end else if (grant_dm) begin
            prio <= SRC_IF;
        end else if (grant_if) begin
            prio <= SRC_DM;
        end
    end

    // Round-robin grant; a lone requester always wins
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!rst) begin
            if (if_req_valid && dm_req_valid) begin
                grant_dm = (prio == SRC_DM);
                grant_if = (prio == SRC_IF);
            end else begin
                grant_if = if_req_valid;
                grant_dm = dm_req_valid;
            end
        end
    end
`else
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [SCW-1:0] starve_cnt;
    logic           starved;

    assign starved = (starve_cnt == SCW'(STARVE_MAX));

    // Count consecutive cycles the fetch port waits; saturates at STARVE_MAX
    always_ff @(posedge clk) begin
        if (rst || !if_req_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

    // Data port wins unless the fetch port has waited STARVE_MAX cycles
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!rst) begin
            grant_dm = dm_req_valid && !(if_req_valid && starved);
            grant_if = if_req_valid && !grant_dm;
        end
    end
`endif

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;
    assign grant_rd     = grant_if || (grant_dm && !dm_req_we);

    // Present the granted request to the memory; idle bus is all zeros
    always_comb begin
        mem_en    = grant_if || grant_dm;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm) begin
            mem_addr = dm_req_addr;
            if (dm_req_we) begin
                mem_we    = dm_req_wmask;
                mem_wdata = dm_req_wdata;
            end
        end else if (grant_if) begin
            mem_addr = if_req_addr;
        end
    end

    // Tag pipeline: one {valid, src} entry per cycle, aligned to read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v   <= '0;
            tag_src <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_v[i]   <= tag_v[i-1];
                tag_src[i] <= tag_src[i-1];
            end
            tag_v[0]   <= grant_rd;
            tag_src[0] <= grant_dm ? SRC_DM : SRC_IF;
        end
    end

    // Steer returning data to the port recorded in the tag
    always_comb begin
        rsp_v        = tag_v[RD_LAT-1] && !rst;
        if_rsp_valid = rsp_v && (tag_src[RD_LAT-1] == SRC_IF);
        dm_rsp_valid = rsp_v && (tag_src[RD_LAT-1] == SRC_DM);
        if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
        dm_rsp_data  = dm_rsp_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Bench for ama_riscv_mem_arb: three instances (RD_LAT 1, 2, 3) share the
// same stimulus and a behavioural memory with per-latency read pipelines.

module tb_ama_riscv_mem_arb;

    localparam int NI  = 3;
    localparam int G_N = 0;
    localparam int G_F = 1;
    localparam int G_D = 2;

    logic        clk;
    logic        rst;
    logic        if_v;
    logic [13:0] if_a;
    logic        dm_v;
    logic        dm_we;
    logic [13:0] dm_a;
    logic [3:0]  dm_m;
    logic [31:0] dm_d;

    logic        if_rdy [NI];
    logic        dm_rdy [NI];
    logic        ifv    [NI];
    logic [31:0] ifd    [NI];
    logic        dmv    [NI];
    logic [31:0] dmd    [NI];
    logic        en     [NI];
    logic [3:0]  we     [NI];
    logic [13:0] addr   [NI];
    logic [31:0] wd     [NI];

    logic [31:0] mem   [16384];
    logic [31:0] rpipe [4];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        iv;
        logic [13:0] ia;
        logic        dv;
        logic        dwe;
        logic [13:0] da;
        logic [3:0]  msk;
        logic [31:0] dd;
        int          gnt;
        int          rsrc;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ama_riscv_mem_arb #(
            .AW(14), .DW(32), .RD_LAT(g + 1), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req_valid(if_v), .if_req_ready(if_rdy[g]), .if_req_addr(if_a),
            .if_rsp_valid(ifv[g]), .if_rsp_data(ifd[g]),
            .dm_req_valid(dm_v), .dm_req_ready(dm_rdy[g]), .dm_req_addr(dm_a),
            .dm_req_we(dm_we), .dm_req_wmask(dm_m), .dm_req_wdata(dm_d),
            .dm_rsp_valid(dmv[g]), .dm_rsp_data(dmd[g]),
            .mem_en(en[g]), .mem_we(we[g]), .mem_addr(addr[g]), .mem_wdata(wd[g]),
            .mem_rdata(rpipe[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory macro: preloaded on reset, byte writes, read data RD_LAT later
    always @(posedge clk) begin
        rpipe[1] <= rpipe[0];
        rpipe[2] <= rpipe[1];
        rpipe[3] <= rpipe[2];
        rpipe[0] <= (en[0] && we[0] == 4'b0000) ? mem[addr[0]] : 32'h0;
        if (rst) begin
            for (int i = 0; i < 16384; i++) mem[i] = w(i);
        end else if (en[0]) begin
            for (int b = 0; b < 4; b++)
                if (we[0][b]) mem[addr[0]][8*b +: 8] = wd[0][8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input int ia, input logic dv, input logic dwe,
                         input int da, input logic [3:0] msk, input logic [31:0] dd);
        if_v  = iv;
        if_a  = 14'(ia);
        dm_v  = dv;
        dm_we = dwe;
        dm_a  = 14'(da);
        dm_m  = msk;
        dm_d  = dd;
    endtask

    task automatic chk_zero_all(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s_u%0d_if_rdy", tag, g), 32'(if_rdy[g]), 32'h0);
            chk($sformatf("%s_u%0d_dm_rdy", tag, g), 32'(dm_rdy[g]), 32'h0);
            chk($sformatf("%s_u%0d_mem_en", tag, g), 32'(en[g]), 32'h0);
            chk($sformatf("%s_u%0d_mem_we", tag, g), 32'(we[g]), 32'h0);
            chk($sformatf("%s_u%0d_mem_addr", tag, g), 32'(addr[g]), 32'h0);
            chk($sformatf("%s_u%0d_mem_wdata", tag, g), wd[g], 32'h0);
            chk($sformatf("%s_u%0d_if_rsp_v", tag, g), 32'(ifv[g]), 32'h0);
            chk($sformatf("%s_u%0d_dm_rsp_v", tag, g), 32'(dmv[g]), 32'h0);
        end
    endtask

    function automatic void add(input logic iv, input int ia, input logic dv, input logic dwe,
                                input int da, input logic [3:0] msk, input logic [31:0] dd,
                                input int gnt, input int rsrc, input logic [31:0] rdata);
        vec_t v;
        v.iv = iv; v.ia = 14'(ia); v.dv = dv; v.dwe = dwe; v.da = 14'(da);
        v.msk = msk; v.dd = dd; v.gnt = gnt; v.rsrc = rsrc; v.rdata = rdata;
        tbl.push_back(v);
    endfunction

    // Read-only contention run; pat: B = both valid, D = data only; gnt: F/D per cycle
    function automatic void add_pat(input string pat, input string gnt, input int ia, input int da);
        int prev = G_N;
        int g;
        for (int k = 0; k < pat.len(); k++) begin
            g = (gnt[k] == "F") ? G_F : G_D;
            add(pat[k] == "B", ia, 1'b1, 1'b0, da, 4'h0, 32'h0, g, prev,
                (prev == G_F) ? w(ia) : (prev == G_D) ? w(da) : 32'h0);
            prev = g;
        end
        add(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0, G_N, prev, (prev == G_F) ? w(ia) : w(da));
    endfunction

    initial begin
        logic [31:0] exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        int          k;
        int          src;

        // fetch-only burst 0..7
        for (int i = 0; i < 8; i++)
            add(1'b1, i, 1'b0, 1'b0, 0, 4'h0, 32'h0, G_F, (i == 0) ? G_N : G_F,
                (i == 0) ? 32'h0 : w(i - 1));
        add(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0, G_N, G_F, w(7));
        // partial write then read back
        add(1'b0, 0, 1'b1, 1'b1, 'h10, 4'b0011, 32'hDEAD_BEEF, G_D, G_N, 32'h0);
        add(1'b0, 0, 1'b1, 1'b0, 'h10, 4'h0, 32'h0, G_D, G_N, 32'h0);
        add(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0, G_N, G_D, 32'hA500_BEEF);
        // read then write same word: old data; later read: new data
        add(1'b0, 0, 1'b1, 1'b0, 'h11, 4'h0, 32'h0, G_D, G_N, 32'h0);
        add(1'b0, 0, 1'b1, 1'b1, 'h11, 4'hF, 32'h1234_5678, G_D, G_D, w('h11));
        add(1'b0, 0, 1'b1, 1'b0, 'h11, 4'h0, 32'h0, G_D, G_N, 32'h0);
        add(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0, G_N, G_D, 32'h1234_5678);
`ifdef MEM_ARB_RR_EN
        add_pat("BBBBBBB", "FDFDFDF", 'h40, 'h41);
        add_pat("BBBDBBBBB", "DFDDFDFDF", 'h50, 'h51);
`else
        add_pat("BBBBBBB", "DDDDFDD", 'h40, 'h41);
        add_pat("BBBDBBBBB", "DDDDDDDDF", 'h50, 'h51);
`endif

        rst = 1'b1;
        drive(1'b1, 3, 1'b1, 1'b1, 3, 4'hF, 32'hFFFF_FFFF);
        repeat (2) begin
            @(negedge clk);
            chk_zero_all("rst_init");
        end
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[r]) begin
            drive(tbl[r].iv, int'(tbl[r].ia), tbl[r].dv, tbl[r].dwe, int'(tbl[r].da),
                  tbl[r].msk, tbl[r].dd);
            @(negedge clk);
            exp_we   = (tbl[r].gnt == G_D && tbl[r].dwe) ? 32'(tbl[r].msk) : 32'h0;
            exp_wd   = (tbl[r].gnt == G_D && tbl[r].dwe) ? tbl[r].dd : 32'h0;
            exp_addr = (tbl[r].gnt == G_F) ? 32'(tbl[r].ia) :
                       (tbl[r].gnt == G_D) ? 32'(tbl[r].da) : 32'h0;
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("row%0d_u%0d_if_rdy", r, g), 32'(if_rdy[g]), 32'(tbl[r].gnt == G_F));
                chk($sformatf("row%0d_u%0d_dm_rdy", r, g), 32'(dm_rdy[g]), 32'(tbl[r].gnt == G_D));
                chk($sformatf("row%0d_u%0d_mem_en", r, g), 32'(en[g]), 32'(tbl[r].gnt != G_N));
                chk($sformatf("row%0d_u%0d_mem_we", r, g), 32'(we[g]), exp_we);
                chk($sformatf("row%0d_u%0d_mem_addr", r, g), 32'(addr[g]), exp_addr);
                chk($sformatf("row%0d_u%0d_mem_wdata", r, g), wd[g], exp_wd);
            end
            chk($sformatf("row%0d_if_rsp_v", r), 32'(ifv[0]), 32'(tbl[r].rsrc == G_F));
            chk($sformatf("row%0d_if_rsp_d", r), ifd[0],
                (tbl[r].rsrc == G_F) ? tbl[r].rdata : 32'h0);
            chk($sformatf("row%0d_dm_rsp_v", r), 32'(dmv[0]), 32'(tbl[r].rsrc == G_D));
            chk($sformatf("row%0d_dm_rsp_d", r), dmd[0],
                (tbl[r].rsrc == G_D) ? tbl[r].rdata : 32'h0);
            @(posedge clk); #1;
        end

        drive(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // interleaved F 0x20 / D 0x21 reads, checked on all three latencies
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 2:    drive(1'b1, 'h20, 1'b0, 1'b0, 0, 4'h0, 32'h0);
                1, 3:    drive(1'b0, 0, 1'b1, 1'b0, 'h21, 4'h0, 32'h0);
                default: drive(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
            endcase
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("il%0d_if_rdy", c), 32'(if_rdy[0]), 32'(c % 2 == 0));
                chk($sformatf("il%0d_dm_rdy", c), 32'(dm_rdy[0]), 32'(c % 2 == 1));
            end
            for (int g = 0; g < NI; g++) begin
                k   = c - (g + 1);
                src = (k < 0 || k > 3) ? G_N : (k % 2 == 0) ? G_F : G_D;
                chk($sformatf("il%0d_u%0d_if_rsp_v", c, g), 32'(ifv[g]), 32'(src == G_F));
                chk($sformatf("il%0d_u%0d_if_rsp_d", c, g), ifd[g],
                    (src == G_F) ? w('h20) : 32'h0);
                chk($sformatf("il%0d_u%0d_dm_rsp_v", c, g), 32'(dmv[g]), 32'(src == G_D));
                chk($sformatf("il%0d_u%0d_dm_rsp_d", c, g), dmd[g],
                    (src == G_D) ? w('h21) : 32'h0);
            end
            @(posedge clk); #1;
        end

        // read granted, then reset the next cycle: the read must vanish
        drive(1'b0, 0, 1'b1, 1'b0, 'h30, 4'h0, 32'h0);
        @(negedge clk);
        chk("rs_dm_rdy", 32'(dm_rdy[0]), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 'h31, 1'b1, 1'b1, 'h32, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk_zero_all("rs_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("rs_post%0d_u%0d_if_rsp_v", c, g), 32'(ifv[g]), 32'h0);
                chk($sformatf("rs_post%0d_u%0d_dm_rsp_v", c, g), 32'(dmv[g]), 32'h0);
                chk($sformatf("rs_post%0d_u%0d_dm_rsp_d", c, g), dmd[g], 32'h0);
            end
            @(posedge clk); #1;
        end

        // arbitration state after reset: data port first
        drive(1'b1, 'h40, 1'b1, 1'b0, 'h41, 4'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_c0_dm_rdy", 32'(dm_rdy[0]), 32'h1);
        chk("post_rst_c0_if_rdy", 32'(if_rdy[0]), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        chk("post_rst_c1_if_rdy", 32'(if_rdy[0]), 32'h1);
        chk("post_rst_c1_dm_rdy", 32'(dm_rdy[0]), 32'h0);
`else
        chk("post_rst_c1_if_rdy", 32'(if_rdy[0]), 32'h0);
        chk("post_rst_c1_dm_rdy", 32'(dm_rdy[0]), 32'h1);
`endif
        @(posedge clk); #1;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
